// File: rtl/game_pkg.sv
// Shared game constants, scheduler state encoding and LFSR/speed-up constants
// used by the enemy fire scheduler and its LFSR.
package game_pkg;

  localparam int COORD_W   = 10;
  localparam int N_ENEMIES = 5;
  localparam int N_SLOTS   = 5;

  // Fibonacci taps for x^8 + x^6 + x^5 + x^4 + 1 (state bits 7,5,4,3)
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  localparam int SPEEDUP_STEP  = 4;
  localparam int SPEEDUP_FLOOR = 6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    ALLOC  = 2'd2,
    ISSUE  = 2'd3
  } sched_state_t;

endpackage

// File: rtl/enemy_fire_scheduler_if.sv
// Spawn command handshake between the fire scheduler (master) and the
// enemy-projectile slot datapath (slave).
interface enemy_fire_scheduler_if #(
  parameter int COORD_W = game_pkg::COORD_W
);
  logic               spawn_valid;
  logic               spawn_ready;
  logic [2:0]         spawn_slot;
  logic [COORD_W-1:0] spawn_x;
  logic [COORD_W-1:0] spawn_y;

  modport master (
    output spawn_valid, spawn_slot, spawn_x, spawn_y,
    input  spawn_ready
  );

  modport slave (
    input  spawn_valid, spawn_slot, spawn_x, spawn_y,
    output spawn_ready
  );
endinterface

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR with load-on-reset seed and a step enable.
module lfsr8 #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [7:0] state
);
  import game_pkg::*;

  logic fb;

  assign fb = ^(state & LFSR_TAPS);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SEED;
    end else if (en) begin
      state <= {state[6:0], fb};
    end
  end
endmodule

// File: rtl/enemy_fire_scheduler.sv
// Picks a live invader to shoot and a free projectile slot, then issues one
// spawn command over a valid/ready handshake. Optional: ENEMY_FIRE_SPEEDUP_EN.
module enemy_fire_scheduler #(
  parameter int         N_ENEMIES       = 5,
  parameter int         N_SLOTS         = 5,
  parameter int         COORD_W         = 10,
  parameter int         COOLDOWN_FRAMES = 30,
  parameter int         X_OFFSET        = 8,
  parameter int         Y_OFFSET        = 16,
  parameter logic [7:0] LFSR_SEED       = 8'hA5
) (
  input  logic                         CLOCK_50,
  input  logic                         reset,
  input  logic                         pausa,
  input  logic                         frame_tick,
  input  logic [N_ENEMIES-1:0]         inimigo_vivo_array,
  input  logic [N_ENEMIES*COORD_W-1:0] inimigo_x,
  input  logic [N_ENEMIES*COORD_W-1:0] inimigo_y,
  input  logic [N_SLOTS-1:0]           slot_busy,
  enemy_fire_scheduler_if.master       spawn,
  output logic [7:0]                   shots_fired,
  output logic                         sched_busy
);
  import game_pkg::*;

  localparam int IDX_W  = (N_ENEMIES > 1) ? $clog2(N_ENEMIES) : 1;
  localparam int PRB_W  = $clog2(N_ENEMIES + 1);
  localparam int CD_MAX = (COOLDOWN_FRAMES > SPEEDUP_FLOOR) ? COOLDOWN_FRAMES : SPEEDUP_FLOOR;
  localparam int CD_W   = $clog2(CD_MAX + 1);

  sched_state_t       state;
  sched_state_t       state_next;
  logic [7:0]         lfsr;
  logic [CD_W-1:0]    cooldown;
  logic [CD_W-1:0]    reload;
  logic [IDX_W-1:0]   idx;
  logic [PRB_W-1:0]   probes;
  logic               handshake;
  logic               cand_alive;
  logic [COORD_W-1:0] cand_x;
  logic [COORD_W-1:0] cand_y;
  logic               slot_free;
  logic [2:0]         free_slot;

  function automatic logic [COORD_W-1:0] sat_add(input logic [COORD_W-1:0] a,
                                                 input int unsigned        off);
    logic [COORD_W:0] sum;
    sum = {1'b0, a} + (COORD_W+1)'(off);
    return sum[COORD_W] ? {COORD_W{1'b1}} : sum[COORD_W-1:0];
  endfunction

  function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(N_ENEMIES - 1)) ? '0 : i + 1'b1;
  endfunction

  function automatic logic [IDX_W-1:0] start_idx(input logic [7:0] r);
    return IDX_W'(r % 8'(N_ENEMIES));
  endfunction

`ifdef ENEMY_FIRE_SPEEDUP_EN
  // Each dead invader shortens the next cooldown, down to a fixed floor.
  function automatic logic [CD_W-1:0] speedup_reload(input logic [N_ENEMIES-1:0] alive);
    int r;
    r = COOLDOWN_FRAMES - SPEEDUP_STEP * (N_ENEMIES - $countones(alive));
    if (r < SPEEDUP_FLOOR) r = SPEEDUP_FLOOR;
    return CD_W'(r);
  endfunction

  assign reload = speedup_reload(inimigo_vivo_array);
`else
  assign reload = CD_W'(COOLDOWN_FRAMES);
`endif

  lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (CLOCK_50),
    .rst   (reset),
    .en    (~pausa),
    .state (lfsr)
  );

  assign handshake         = spawn.spawn_valid & spawn.spawn_ready;
  assign spawn.spawn_valid = (state == ISSUE);
  assign sched_busy        = (state != IDLE);

  // Current candidate / latched shooter: idx holds the shooter once SELECT finds one.
  always_comb begin
    cand_alive = 1'b0;
    cand_x     = '0;
    cand_y     = '0;
    for (int i = 0; i < N_ENEMIES; i++) begin
      if (IDX_W'(i) == idx) begin
        cand_alive = inimigo_vivo_array[i];
        cand_x     = inimigo_x[i*COORD_W +: COORD_W];
        cand_y     = inimigo_y[i*COORD_W +: COORD_W];
      end
    end
  end

  always_comb begin
    slot_free = 1'b0;
    free_slot = '0;
    for (int s = N_SLOTS - 1; s >= 0; s--) begin
      if (!slot_busy[s]) begin
        slot_free = 1'b1;
        free_slot = 3'(s);
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (cooldown == '0 && !pausa) state_next = SELECT;
      end
      SELECT: begin
        if (cand_alive)                             state_next = ALLOC;
        else if (probes == PRB_W'(N_ENEMIES - 1))   state_next = IDLE;
      end
      ALLOC: begin
        if (!cand_alive)    state_next = SELECT;
        else if (slot_free) state_next = ISSUE;
      end
      ISSUE: begin
        if (handshake) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // A reload on the handshake takes priority over a coincident frame tick.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      cooldown <= CD_W'(COOLDOWN_FRAMES);
    end else if (handshake) begin
      cooldown <= reload;
    end else if (frame_tick && !pausa && cooldown != '0) begin
      cooldown <= cooldown - 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      idx              <= '0;
      probes           <= '0;
      spawn.spawn_slot <= '0;
      spawn.spawn_x    <= '0;
      spawn.spawn_y    <= '0;
      shots_fired      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (state_next == SELECT) begin
            idx    <= start_idx(lfsr);
            probes <= '0;
          end
        end
        SELECT: begin
          if (cand_alive) begin
            spawn.spawn_x <= sat_add(cand_x, X_OFFSET);
            spawn.spawn_y <= sat_add(cand_y, Y_OFFSET);
          end else begin
            idx    <= idx_inc(idx);
            probes <= probes + 1'b1;
          end
        end
        ALLOC: begin
          if (!cand_alive) begin
            idx    <= idx_inc(idx);
            probes <= '0;
          end else if (slot_free) begin
            spawn.spawn_slot <= free_slot;
          end
        end
        ISSUE: begin
          if (handshake) shots_fired <= shots_fired + 8'd1;
        end
        default: ;
      endcase
    end
  end
endmodule
